// File: rtl/jtag_cnfg_pkg.sv
// Shared constants for the JTAG configuration-memory deserializer:
// status-word bit layout, default geometry and the FIFO level width helper.
package jtag_cnfg_pkg;

    localparam int STAT_OVF     = 0;
    localparam int STAT_PART    = 1;
    localparam int STAT_LVL_LSB = 2;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // The level must be able to represent DEPTH itself, hence one extra bit.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jtag_cnfgmem_deserializer_fifo.sv
// First-word-fall-through word buffer between the TAP shift path and the
// bitstream loader. A push into a full FIFO only succeeds alongside a pop.
module cnfg_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             tck_i,
    input  logic             trst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == LVL_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign level    = count;
    // Drive zero while empty so the loader never sees stale data.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge tck_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/jtag_cnfgmem_deserializer.sv
// Deserializes cnfgmem DR shift data LSB-first into configuration words,
// buffers them for the loader and returns a status word on TDO.
module jtag_cnfgmem_deserializer
    import jtag_cnfg_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic              tck_i,
    input  logic              trst_i,
    input  logic              cnfgmem_select_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              partial_o,
    output logic [CNT_W-1:0]  word_count_o
);

    localparam int LVL_W = lvl_width(FIFO_DEPTH);
    localparam int BC_W  = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] status;
    logic [BC_W-1:0]   bit_cnt;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              do_cap;
    logic              do_upd;
    logic              do_shift;
    logic              word_done;
    logic              pop;
    logic              push_ok;

    // Capture wins over update, which wins over shift.
    assign do_cap    = cnfgmem_select_i & capture_dr_i;
    assign do_upd    = cnfgmem_select_i & update_dr_i & ~capture_dr_i;
    assign do_shift  = cnfgmem_select_i & shift_dr_i & ~capture_dr_i & ~update_dr_i;

    assign shifted   = {tdi_i, sr[WORD_W-1:1]};
    assign word_done = do_shift & (bit_cnt == LAST_BIT);
    assign pop       = ~fifo_empty & word_ready_i;
    assign push_ok   = word_done & (~fifo_full | pop);

    assign tdo_o        = sr[0];
    assign word_valid_o = ~fifo_empty;

    always_comb begin
        status                         = '0;
        status[STAT_OVF]               = overflow_o;
        status[STAT_PART]              = partial_o;
        status[STAT_LVL_LSB +: LVL_W]  = fifo_level;
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            sr           <= '0;
            bit_cnt      <= '0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            partial_o    <= 1'b0;
            word_count_o <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (do_cap) begin
                sr           <= status;
                bit_cnt      <= '0;
                word_count_o <= '0;
            end else if (do_upd) begin
                // Partial bits stay in sr but are dead: the next word overwrites all of them.
                if (bit_cnt == '0) frame_done_o <= 1'b1;
                else               partial_o    <= 1'b1;
                bit_cnt <= '0;
            end else if (do_shift) begin
                sr <= shifted;
                if (word_done) begin
                    bit_cnt <= '0;
                    if (push_ok) begin
                        if (word_count_o != '1) word_count_o <= word_count_o + 1'b1;
                    end else begin
                        overflow_o <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    cnfg_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .tck_i     (tck_i),
        .trst_i    (trst_i),
        .push      (word_done),
        .push_data (shifted),
        .pop       (pop),
        .pop_data  (word_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_jtag_cnfgmem_deserializer.sv
// Directed bench for jtag_cnfgmem_deserializer with WORD_W=8, FIFO_DEPTH=4:
// a vector table for single-word deserialization plus hand-written corner cases.
module tb_jtag_cnfgmem_deserializer;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic              tck = 1'b0;
    logic              trst;
    logic              sel;
    logic              cap;
    logic              shf;
    logic              upd;
    logic              tdi;
    logic              tdo;
    logic [WORD_W-1:0] word;
    logic              valid;
    logic              ready;
    logic              frame_done;
    logic              overflow;
    logic              partial;
    logic [CNT_W-1:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    // seq is written in shift order: seq[7] is the first bit on TDI.
    typedef struct {
        logic [7:0] seq;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    always #5 tck = ~tck;

    jtag_cnfgmem_deserializer #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .tck_i            (tck),
        .trst_i           (trst),
        .cnfgmem_select_i (sel),
        .capture_dr_i     (cap),
        .shift_dr_i       (shf),
        .update_dr_i      (upd),
        .tdi_i            (tdi),
        .tdo_o            (tdo),
        .word_o           (word),
        .word_valid_o     (valid),
        .word_ready_i     (ready),
        .frame_done_o     (frame_done),
        .overflow_o       (overflow),
        .partial_o        (partial),
        .word_count_o     (count)
    );

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        trst = 1'b1; sel = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0; tdi = 1'b0; ready = 1'b0;
        tick();
        trst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " tdo"},        32'(tdo),        32'h0);
        checkOutput({tag, " valid"},      32'(valid),      32'h0);
        checkOutput({tag, " word"},       32'(word),       32'h0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 32'h0);
        checkOutput({tag, " overflow"},   32'(overflow),   32'h0);
        checkOutput({tag, " partial"},    32'(partial),    32'h0);
        checkOutput({tag, " count"},      32'(count),      32'h0);
    endtask

    task automatic do_capture();
        sel = 1'b1; cap = 1'b1;
        tick();
        cap = 1'b0;
    endtask

    task automatic do_update();
        sel = 1'b1; upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        sel = 1'b1; shf = 1'b1; tdi = b;
        tick();
        shf = 1'b0;
    endtask

    // Shifts a word LSB-first, so w[0] goes out first.
    task automatic shift_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) shift_bit(w[i]);
    endtask

    // Reads tdo before each shift edge, collecting the status word LSB-first.
    task automatic read_status(output logic [7:0] s);
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = tdo;
            shift_bit(1'b0);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        checkOutput({name, " valid"}, 32'(valid), 32'h1);
        checkOutput({name, " word"},  32'(word),  32'(exp));
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        do_capture();
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) checkOutput($sformatf("vec%0d valid_before_last", idx), 32'(valid), 32'h0);
            shift_bit(vecs[idx].seq[i]);
        end
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] w;

        vecs[0] = '{seq: 8'b10100101, exp_word: 8'hA5};
        vecs[1] = '{seq: 8'b00000001, exp_word: 8'h80};
        vecs[2] = '{seq: 8'b10000000, exp_word: 8'h01};
        vecs[3] = '{seq: 8'b11000010, exp_word: 8'h43};
        vecs[4] = '{seq: 8'b01101001, exp_word: 8'h96};
        vecs[5] = '{seq: 8'b11111111, exp_word: 8'hFF};

        do_reset();
        check_all_zero("reset");

        // Single-word deserialization table
        for (int v = 0; v < 6; v++) begin
            applyStimulus(v);
            checkOutput($sformatf("vec%0d valid", v), 32'(valid), 32'h1);
            checkOutput($sformatf("vec%0d word", v),  32'(word),  32'(vecs[v].exp_word));
            checkOutput($sformatf("vec%0d count", v), 32'(count), 32'h1);
            ready = 1'b1;
            tick();
            ready = 1'b0;
            checkOutput($sformatf("vec%0d drained", v), 32'(valid), 32'h0);
        end

        // Overflow: five words into a depth-4 FIFO with no reader
        do_reset();
        shift_word(8'h11); shift_word(8'h22); shift_word(8'h33); shift_word(8'h44);
        checkOutput("ovf before word5", 32'(overflow), 32'h0);
        shift_word(8'h55);
        checkOutput("ovf after word5", 32'(overflow), 32'h1);
        checkOutput("ovf count", 32'(count), 32'h4);
        do_capture();
        checkOutput("ovf cap count", 32'(count), 32'h0);
        checkOutput("ovf cap tdo", 32'(tdo), 32'h1);
        read_status(st);
        checkOutput("ovf status", 32'(st), 32'h11);
        checkOutput("ovf status dropped count", 32'(count), 32'h0);
        pop_check("ovf pop1", 8'h11);
        pop_check("ovf pop2", 8'h22);
        pop_check("ovf pop3", 8'h33);
        pop_check("ovf pop4", 8'h44);
        checkOutput("ovf empty", 32'(valid), 32'h0);

        // Full FIFO, pop on the same edge the fifth word completes
        do_reset();
        shift_word(8'hA1); shift_word(8'hA2); shift_word(8'hA3); shift_word(8'hA4);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) shift_bit(w[i]);
        checkOutput("fullpop head", 32'(word), 32'hA1);
        ready = 1'b1;
        shift_bit(w[7]);
        ready = 1'b0;
        checkOutput("fullpop ovf", 32'(overflow), 32'h0);
        checkOutput("fullpop count", 32'(count), 32'h5);
        do_capture();
        read_status(st);
        checkOutput("fullpop status", 32'(st), 32'h10);
        pop_check("fullpop pop2", 8'hA2);
        pop_check("fullpop pop3", 8'hA3);
        pop_check("fullpop pop4", 8'hA4);
        pop_check("fullpop pop5", 8'hA5);
        checkOutput("fullpop empty", 32'(valid), 32'h0);

        // Partial word on update, then a clean two-word frame
        do_reset();
        do_capture();
        shift_word(8'h3C);
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        checkOutput("partial before upd", 32'(partial), 32'h0);
        do_update();
        checkOutput("partial flag", 32'(partial), 32'h1);
        checkOutput("partial no frame_done", 32'(frame_done), 32'h0);
        checkOutput("partial count", 32'(count), 32'h1);
        pop_check("partial pop", 8'h3C);
        shift_word(8'h12);
        shift_word(8'h34);
        do_update();
        checkOutput("frame_done pulse", 32'(frame_done), 32'h1);
        tick();
        checkOutput("frame_done single", 32'(frame_done), 32'h0);
        checkOutput("frame count", 32'(count), 32'h3);
        checkOutput("partial sticky", 32'(partial), 32'h1);

        // Reset mid-shift with two words buffered
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        checkOutput("rst pre valid", 32'(valid), 32'h1);
        do_reset();
        check_all_zero("midrst");
        shift_word(8'h5A);
        checkOutput("midrst word", 32'(word), 32'h5A);
        checkOutput("midrst count", 32'(count), 32'h1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("midrst one word", 32'(valid), 32'h0);

        // Deselected shifting must leave sr, bit_cnt and FIFO alone
        do_reset();
        w = 8'hB3;
        for (int i = 0; i < 3; i++) shift_bit(w[i]);
        sel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            shf = i[0];
            tdi = 1'($urandom_range(0, 1));
            tick();
        end
        shf = 1'b0;
        checkOutput("desel valid", 32'(valid), 32'h0);
        checkOutput("desel count", 32'(count), 32'h0);
        for (int i = 3; i < 8; i++) shift_bit(w[i]);
        checkOutput("desel resume word", 32'(word), 32'hB3);
        checkOutput("desel resume count", 32'(count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
